fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register of the pipelined RV32I core.
//  Holds PC, issues requests to a variable-latency instruction memory, and applies redirects
//  from execute (PCSrc: 00 PC+4, 01 PCTarget, 10 JALR).
//  Delivers InstrD/PCD/PCPlus4D to decode, whose opcode/funct fields feed the control unit.
//  Honours hazard-unit stall; squashes IF/ID on redirect.
// PARAMETERS
//  DATA_WIDTH  32            datapath/PC width
//  RESET_PC    32'h0000_0000 PC value loaded on reset
//  NOP_INSTR   32'h0000_0013 bubble instruction (addi x0,x0,0)
// PORTS
//  clk        in  1   sole clock, rising edge
//  rst_n      in  1   synchronous, active-low reset
//  PCSrcE     in  2   next-PC select from execute; 00 = no redirect
//  PCTargetE  in  32  PC+imm target (branch/JAL)
//  ALUResultE in  32  JALR target before bit-0 clear
//  StallF     in  1   hazard unit: hold IF/ID and PC
//  imem_req   out 1   fetch request; held with stable imem_addr until imem_valid
//  imem_addr  out 32  fetch address (= PCF, or held address in DISCARD)
//  imem_rdata in  32  instruction, qualified by imem_valid
//  imem_valid in  1   response; may coincide with imem_req (zero-wait)
//  InstrD     out 32  decode instruction
//  PCD        out 32  PC of InstrD
//  PCPlus4D   out 32  PCD+4
//  ValidD     out 1   InstrD is real (0 = bubble)
//  MisalignF  out 1   misaligned redirect pulse (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n=0 at edge): PCF=RESET_PC, state=FETCH, InstrD=NOP_INSTR, PCD=PCPlus4D=0, ValidD=0,
//   MisalignF=0. Pending response is abandoned; imem drops it. Combinational imem_req=1 after reset.
//  Redirect = (PCSrcE!=00). Target = PCSrcE==01 ? PCTargetE : ALUResultE & ~32'h1. PCSrcE==11 is
//   illegal; treat as 00.
//  Priority: rst_n > redirect > StallF > normal advance.
//  Redirect, any state: IF/ID <= {NOP_INSTR, ValidD=0} regardless of StallF; PCF <= target.
//  FSM (enum in package):
//   FETCH: imem_req=1, imem_addr=PCF.
//    redirect & imem_valid -> drop data, stay FETCH. redirect & !imem_valid -> DISCARD.
//    imem_valid & !StallF -> IF/ID <= {imem_rdata,PCF,PCF+4,1}; PCF += 4; stay.
//    imem_valid & StallF -> hold_buf <= imem_rdata; -> HOLD; IF/ID unchanged.
//    !imem_valid & !StallF -> IF/ID <= bubble. !imem_valid & StallF -> IF/ID unchanged.
//   DISCARD: imem_req=1, imem_addr=old (held) address until imem_valid; response dropped -> FETCH.
//    Further redirect here overwrites PCF only.
//   HOLD: imem_req=0. !StallF -> IF/ID <= {hold_buf,PCF,PCF+4,1}; PCF += 4; -> FETCH.
//    Redirect -> drop hold_buf -> FETCH.
//  Throughput: one instr/cycle with zero-wait imem. Latency: imem_valid edge -> InstrD next cycle.
//  PC arithmetic modulo 2^32; 0xFFFF_FFFC + 4 wraps to 0. No instruction lost/duplicated across stall.
// CONFIGURATION
//  FETCH_MISALIGN_CHECK_EN defined: target[1]==1 on redirect -> MisalignF=1 for one cycle
//   (registered). Target still taken with bits[1:0] forced to 00.
//  Undefined: MisalignF tied 0; target used as computed (bit 0 cleared for JALR only).
// STRUCTURE
//  fetch_pkg: fetch_state_t {FETCH,DISCARD,HOLD}; PCSRC_PLUS4=2'b00, PCSRC_BRANCH=2'b01,
//   PCSRC_JALR=2'b10; NOP_INSTR constant.
//  Sub-module fetch_pc_sel: combinational redirect/target select (PCSrcE,PCTargetE,ALUResultE
//   -> redirect,target).
//  FSM, PCF, hold_buf, IF/ID regs in fetch_stage.
// TESTING
//  1 Reset, zero-wait imem returns addr-tagged words: PCD 0,4,8 on consecutive cycles, ValidD=1.
//  2 StallF=1 for 3 cycles, imem_valid in first: InstrD frozen, HOLD, imem_req=0; release -> next
//    word exactly once.
//  3 PCSrcE=01, PCTargetE=0x100 while StallF=1: ValidD=0 next cycle; next valid PCD=0x100.
//  4 Redirect to 0x40 during 3-cycle imem wait: imem_addr stays old until valid; old word dropped;
//    next req addr 0x40.
//  5 PCSrcE=10, ALUResultE=0x203: next fetch addr 0x202 (0x200 with _EN), MisalignF=1 with _EN.
//  6 rst_n=0 mid-WAIT/HOLD: next cycle PCF=RESET_PC, ValidD=0, InstrD=0x00000013.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
// Imported by the fetch RTL and its bench.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DISCARD = 2'd1,
    HOLD    = 2'd2
  } fetch_state_t;

  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JALR   = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bundle.
// The fetch stage is the master; the memory is the slave.
interface fetch_if #(
  parameter int DW = 32
);

  logic          imem_req;
  logic [DW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata;
  logic          imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );

endinterface

// File: rtl/fetch_pc_sel.sv
// Redirect detection and next-PC target select from execute.
// PCSrcE==11 is treated as no redirect.
module fetch_pc_sel
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            i_pcsrc,
  input  logic [DATA_WIDTH-1:0] i_pc_target,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  output logic                  o_redirect,
  output logic [DATA_WIDTH-1:0] o_target
);

  always_comb begin
    o_redirect = 1'b0;
    o_target   = i_pc_target;
    unique case (1'b1)
      (i_pcsrc == PCSRC_BRANCH): begin
        o_redirect = 1'b1;
        o_target   = i_pc_target;
      end
      (i_pcsrc == PCSRC_JALR): begin
        o_redirect = 1'b1;
        o_target   = i_alu_result & ~DATA_WIDTH'(1);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage with IF/ID register and variable-latency imem.
// Optional: FETCH_MISALIGN_CHECK_EN flags and aligns misaligned redirects.
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = fetch_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  input  logic [DATA_WIDTH-1:0] ALUResultE,
  input  logic                  StallF,
  fetch_if.master               imem,
  output logic [DATA_WIDTH-1:0] InstrD,
  output logic [DATA_WIDTH-1:0] PCD,
  output logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic                  ValidD,
  output logic                  MisalignF
);

  import fetch_pkg::*;

  fetch_state_t          r_state, w_nstate;
  logic [DATA_WIDTH-1:0] r_pcf, r_disc_addr, r_hold_buf;
  logic [DATA_WIDTH-1:0] r_instr, r_pcd, r_pc4;
  logic                  r_valid, r_mis;

  logic                  w_redirect, w_mis;
  logic [DATA_WIDTH-1:0] w_target_raw, w_target;
  logic                  w_req;
  logic [DATA_WIDTH-1:0] w_addr;
  logic                  w_load_mem, w_load_hold, w_bubble;
  logic                  w_cap_buf, w_cap_disc;

  fetch_pc_sel #(.DATA_WIDTH(DATA_WIDTH)) u_pc_sel (
    .i_pcsrc      (PCSrcE),
    .i_pc_target  (PCTargetE),
    .i_alu_result (ALUResultE),
    .o_redirect   (w_redirect),
    .o_target     (w_target_raw)
  );

`ifdef FETCH_MISALIGN_CHECK_EN
  assign w_target = w_target_raw & ~DATA_WIDTH'(3);
  assign w_mis    = w_redirect & w_target_raw[1];
`else
  assign w_target = w_target_raw;
  assign w_mis    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_nstate;
  end

  // A request stays outstanding until imem_valid, even across redirects.
  always_comb begin
    w_nstate    = r_state;
    w_req       = 1'b1;
    w_addr      = r_pcf;
    w_load_mem  = 1'b0;
    w_load_hold = 1'b0;
    w_bubble    = 1'b0;
    w_cap_buf   = 1'b0;
    w_cap_disc  = 1'b0;
    unique case (r_state)
      FETCH: begin
        if (w_redirect) begin
          w_nstate   = imem.imem_valid ? FETCH : DISCARD;
          w_cap_disc = !imem.imem_valid;
        end else if (imem.imem_valid && !StallF) begin
          w_load_mem = 1'b1;
        end else if (imem.imem_valid) begin
          w_cap_buf = 1'b1;
          w_nstate  = HOLD;
        end else if (!StallF) begin
          w_bubble = 1'b1;
        end
      end
      DISCARD: begin
        w_addr = r_disc_addr;
        if (imem.imem_valid) w_nstate = FETCH;
        if (!w_redirect && !StallF) w_bubble = 1'b1;
      end
      HOLD: begin
        w_req = 1'b0;
        if (w_redirect) begin
          w_nstate = FETCH;
        end else if (!StallF) begin
          w_load_hold = 1'b1;
          w_nstate    = FETCH;
        end
      end
      default: w_nstate = FETCH;
    endcase
  end

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = w_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pcf       <= RESET_PC;
      r_disc_addr <= '0;
      r_hold_buf  <= '0;
      r_instr     <= NOP_INSTR;
      r_pcd       <= '0;
      r_pc4       <= '0;
      r_valid     <= 1'b0;
      r_mis       <= 1'b0;
    end else begin
      r_mis <= w_mis;
      if (w_cap_buf)  r_hold_buf  <= imem.imem_rdata;
      if (w_cap_disc) r_disc_addr <= r_pcf;
      if (w_redirect) begin
        r_pcf   <= w_target;
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end else if (w_load_mem || w_load_hold) begin
        r_instr <= w_load_mem ? imem.imem_rdata : r_hold_buf;
        r_pcd   <= r_pcf;
        r_pc4   <= r_pcf + DATA_WIDTH'(4);
        r_valid <= 1'b1;
        r_pcf   <= r_pcf + DATA_WIDTH'(4);
      end else if (w_bubble) begin
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end
    end
  end

  assign InstrD    = r_instr;
  assign PCD       = r_pcd;
  assign PCPlus4D  = r_pc4;
  assign ValidD    = r_valid;
  assign MisalignF = r_mis;

endmodule
